// File: rtl/dac_serial_tx.sv
// Serializer from the wavetable sample source to the codec DACDAT pin.
// One handshaked sample per daclrck low phase, shifted out MSB-first on synchronized bclk falls.
module dac_serial_tx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_50,
    input  logic              daclrck,
    input  logic              bclk,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ack,
    output logic              dacdat,
    output logic              busy,
    output logic              underrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [DATA_W-1:0]  shift_reg, shift_n;
    logic [CNT_W-1:0]   bit_cnt, cnt_n;
    logic               dacdat_n, ack_n, busy_n, under_n;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   bclk_s, bclk_prev, bclk_fall;

    // Reset clears the chain, so a bclk already high at release shows up as a rise, not a fall.
    always_ff @(posedge clk_50 or posedge daclrck) begin
        if (daclrck) begin
            sync_ff   <= '0;
            bclk_prev <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], bclk};
            bclk_prev <= bclk_s;
        end
    end

    assign bclk_s    = sync_ff[SYNC_STAGES-1];
    assign bclk_fall = bclk_prev & ~bclk_s;

    always_ff @(posedge clk_50 or posedge daclrck) begin
        if (daclrck) begin
            state      <= LOAD;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            dacdat     <= 1'b0;
            sample_ack <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_cnt    <= cnt_n;
            dacdat     <= dacdat_n;
            sample_ack <= ack_n;
            busy       <= busy_n;
            underrun   <= under_n;
        end
    end

    always_comb begin
        state_n  = state;
        shift_n  = shift_reg;
        cnt_n    = bit_cnt;
        dacdat_n = dacdat;
        ack_n    = 1'b0;
        busy_n   = busy;
        under_n  = underrun;
        case (state)
            LOAD: begin
                state_n = SHIFT;
                cnt_n   = CNT_W'(DATA_W - 1);
                busy_n  = 1'b1;
                if (sample_valid) begin
                    shift_n  = sample_in;
                    ack_n    = 1'b1;
                    under_n  = 1'b0;
                    dacdat_n = sample_in[DATA_W-1];
                end else begin
                    shift_n  = '0;
                    under_n  = 1'b1;
                    dacdat_n = 1'b0;
                end
            end
            SHIFT: begin
                if (bclk_fall) begin
                    if (bit_cnt == '0) begin
                        dacdat_n = 1'b0;
                        busy_n   = 1'b0;
                        state_n  = DONE;
                    end else begin
                        shift_n  = {shift_reg[DATA_W-2:0], 1'b0};
                        dacdat_n = shift_reg[DATA_W-2];
                        cnt_n    = bit_cnt - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // Parked until the next daclrck high; extra bclk falls are ignored.
                dacdat_n = 1'b0;
                busy_n   = 1'b0;
            end
            default: begin
                state_n = LOAD;
            end
        endcase
    end

endmodule
